// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-serial RAM bus arbiter (mem_arbiter).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B  = 2'd0;
  localparam logic [1:0] SZ_H  = 2'd1;
  localparam logic [1:0] SZ_W  = 2'd2;
  localparam logic [1:0] IO_HI = 2'b11;

  // Byte count for a MEM access size; the illegal code 3 behaves as a word.
  function automatic logic [2:0] size_to_n(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// Requester pick for mem_arbiter; round-robin when MEM_ARBITER_FAIR_EN is defined,
// otherwise fixed MEM-over-IF priority.
module mem_arbiter_grant
  import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_FAIR_EN
  input  logic clk,
  input  logic rst,
  input  logic take_i,
`endif
  input  logic if_req_i,
  input  logic mem_req_i,
  output logic pick_mem_o
);

`ifdef MEM_ARBITER_FAIR_EN
  logic last_mem_q;

  // Under contention the side that did not win last time gets the bus.
  always_comb pick_mem_o = mem_req_i & (~if_req_i | ~last_mem_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_mem_q <= 1'b0;
    end else if (take_i) begin
      last_mem_q <= pick_mem_o;
    end
  end
`else
  always_comb pick_mem_o = mem_req_i | ~if_req_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF/MEM word requests onto the byte-wide RAM port (little-endian).
// Optional round-robin arbitration: MEM_ARBITER_FAIR_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = mem_arbiter_pkg::IO_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  state_e            state_q;
  logic [2:0]        k_q, n_q;
  logic [ADDR_W-1:0] addr_q, ram_a_q, next_a;
  logic [31:0]       wdata_q, data_q, cap_d, if_data_q, mem_rdata_q;
  logic [7:0]        ram_dout_q, next_byte;
  logic              ram_wr_q, if_done_q, mem_done_q, is_if_q;
  logic              pick_mem, last_k;

`ifdef MEM_ARBITER_FAIR_EN
  logic take;
  assign take = rdy && (state_q == IDLE) && (mem_req || if_req);

  mem_arbiter_grant u_grant (
    .clk        (clk),
    .rst        (rst),
    .take_i     (take),
    .if_req_i   (if_req),
    .mem_req_i  (mem_req),
    .pick_mem_o (pick_mem)
  );
`else
  mem_arbiter_grant u_grant (
    .if_req_i   (if_req),
    .mem_req_i  (mem_req),
    .pick_mem_o (pick_mem)
  );
`endif

  // Byte capture into lane k-1, next write byte and next address.
  always_comb begin
    cap_d = data_q;
    case (k_q)
      3'd1:    cap_d[7:0]   = ram_din;
      3'd2:    cap_d[15:8]  = ram_din;
      3'd3:    cap_d[23:16] = ram_din;
      3'd4:    cap_d[31:24] = ram_din;
      default: ;
    endcase
    case (k_q)
      3'd0:    next_byte = wdata_q[15:8];
      3'd1:    next_byte = wdata_q[23:16];
      3'd2:    next_byte = wdata_q[31:24];
      default: next_byte = wdata_q[7:0];
    endcase
    next_a = addr_q + ADDR_W'(k_q + 3'd1);
    last_k = ((k_q + 3'd1) == n_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      is_if_q     <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else if (rdy) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          k_q    <= '0;
          data_q <= '0;
          if (mem_req && pick_mem) begin
            is_if_q <= 1'b0;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            n_q     <= size_to_n(mem_size);
            ram_a_q <= mem_addr;
            if (mem_we) begin
              state_q    <= WR;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_wdata[7:0];
            end else begin
              state_q <= RD;
            end
          end else if (if_req) begin
            is_if_q <= 1'b1;
            addr_q  <= if_addr;
            n_q     <= 3'd4;
            // Fetches from the I/O window never touch the RAM.
            if (if_addr[17:16] == IO_HI) begin
              state_q   <= DONE;
              if_done_q <= 1'b1;
              if_data_q <= '0;
            end else begin
              state_q <= RD;
              ram_a_q <= if_addr;
            end
          end
        end
        RD: begin
          k_q    <= k_q + 3'd1;
          data_q <= cap_d;
          if (k_q == n_q) begin
            state_q <= DONE;
            ram_a_q <= '0;
            if (is_if_q) begin
              if_data_q <= cap_d;
              if_done_q <= 1'b1;
            end else begin
              mem_rdata_q <= cap_d;
              mem_done_q  <= 1'b1;
            end
          end else if (last_k) begin
            ram_a_q <= '0;
          end else begin
            ram_a_q <= next_a;
          end
        end
        WR: begin
          if (last_k) begin
            state_q    <= DONE;
            ram_wr_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            mem_done_q <= 1'b1;
          end else begin
            k_q        <= k_q + 3'd1;
            ram_a_q    <= next_a;
            ram_dout_q <= next_byte;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pausing holds everything but must not issue writes or completions.
  assign ram_wr    = ram_wr_q & rdy;
  assign if_done   = if_done_q & rdy;
  assign mem_done  = mem_done_q & rdy;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural byte RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_done, mem_done, ram_wr;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int cnt502 = 0;
  logic [31:0] last_wa = '0;
  logic [7:0]  last_wd = '0;
  int base_wr, base_502;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_data   (if_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr)
  );

  always #5 clk = ~clk;

  // RAM contents: a few fixed bytes, otherwise an address-derived pattern.
  function automatic logic [7:0] rd(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h00;
      32'h103: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  always @(posedge clk) begin
    ram_din <= rd(ram_a);
    if (ram_wr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= ram_a;
      last_wd <= ram_dout;
      if (ram_a == 32'h502) cnt502 <= cnt502 + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
    tick(3);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
    check("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
    check("rst_if_done", {31'h0, if_done}, 32'h0);
    check("rst_mem_done", {31'h0, mem_done}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;

    // IF word read at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 4) begin
        check("ifrd_ram_a", ram_a, 32'h100 + 32'(k - 1));
        check("ifrd_ram_wr", {31'h0, ram_wr}, 32'h0);
      end
      check("ifrd_if_done", {31'h0, if_done}, (k == 6) ? 32'h1 : 32'h0);
    end
    check("ifrd_if_data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();
    check("ifrd_done_drop", {31'h0, if_done}, 32'h0);
    check("ifrd_idle_ram_a", ram_a, 32'h0);

    // MEM byte store
    base_wr = wr_cnt;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h0003_0000; mem_wdata = 32'h1234_56AB;
    tick();
    check("sb_ram_wr", {31'h0, ram_wr}, 32'h1);
    check("sb_ram_a", ram_a, 32'h0003_0000);
    check("sb_ram_dout", {24'h0, ram_dout}, 32'h0000_00AB);
    check("sb_early_done", {31'h0, mem_done}, 32'h0);
    tick();
    check("sb_ram_wr_off", {31'h0, ram_wr}, 32'h0);
    check("sb_mem_done", {31'h0, mem_done}, 32'h1);
    check("sb_wr_count", 32'(wr_cnt - base_wr), 32'h1);
    check("sb_last_wa", last_wa, 32'h0003_0000);
    check("sb_last_wd", {24'h0, last_wd}, 32'h0000_00AB);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    check("sb_done_drop", {31'h0, mem_done}, 32'h0);

    // Contention: MEM byte load at 0x200 vs IF at 0x400
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    check("arb_mem_first", ram_a, 32'h200);
    tick(2);
    check("arb_mem_done", {31'h0, mem_done}, 32'h1);
    check("arb_if_not_done", {31'h0, if_done}, 32'h0);
    check("arb_mem_rdata", mem_rdata, 32'h0000_003E);
    mem_req = 1'b0;
    tick();
    check("arb_bubble_ram_a", ram_a, 32'h0);
    tick();
    check("arb_if_second", ram_a, 32'h400);
    tick(5);
    check("arb_if_done", {31'h0, if_done}, 32'h1);
    check("arb_if_data", if_data, 32'h3B3A_3938);
    if_req = 1'b0;
    tick();

    // IF fetch from the I/O window completes without RAM cycles
    if_req = 1'b1; if_addr = 32'h0003_0000;
    tick();
    check("io_if_done", {31'h0, if_done}, 32'h1);
    check("io_if_data", if_data, 32'h0);
    check("io_ram_a", ram_a, 32'h0);
    check("io_ram_wr", {31'h0, ram_wr}, 32'h0);
    if_req = 1'b0;
    tick();
    check("io_done_drop", {31'h0, if_done}, 32'h0);

    // Half load wrapping past the top of the address space
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd1; mem_addr = 32'hFFFF_FFFF;
    tick();
    check("wrap_ram_a0", ram_a, 32'hFFFF_FFFF);
    tick();
    check("wrap_ram_a1", ram_a, 32'h0);
    tick();
    check("wrap_early_done", {31'h0, mem_done}, 32'h0);
    tick();
    check("wrap_mem_done", {31'h0, mem_done}, 32'h1);
    check("wrap_mem_rdata", mem_rdata, 32'h0000_3CC3);
    mem_req = 1'b0;
    tick();

    // Word store paused for three cycles on byte 2
    base_wr = wr_cnt; base_502 = cnt502;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h500; mem_wdata = 32'hDDCC_BBAA;
    tick();
    check("ws_b0_a", ram_a, 32'h500);
    check("ws_b0_d", {24'h0, ram_dout}, 32'h0000_00AA);
    tick();
    check("ws_b1_a", ram_a, 32'h501);
    check("ws_b1_d", {24'h0, ram_dout}, 32'h0000_00BB);
    tick();
    rdy = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      check("ws_pause_wr", {31'h0, ram_wr}, 32'h0);
      check("ws_pause_a", ram_a, 32'h502);
      check("ws_pause_done", {31'h0, mem_done}, 32'h0);
    end
    tick();
    rdy = 1'b1;
    #1;
    check("ws_b2_wr", {31'h0, ram_wr}, 32'h1);
    check("ws_b2_a", ram_a, 32'h502);
    check("ws_b2_d", {24'h0, ram_dout}, 32'h0000_00CC);
    tick();
    check("ws_b3_a", ram_a, 32'h503);
    check("ws_b3_d", {24'h0, ram_dout}, 32'h0000_00DD);
    tick();
    check("ws_mem_done", {31'h0, mem_done}, 32'h1);
    check("ws_wr_off", {31'h0, ram_wr}, 32'h0);
    check("ws_wr_count", 32'(wr_cnt - base_wr), 32'h4);
    check("ws_b2_once", 32'(cnt502 - base_502), 32'h1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();

    // Reset during a word read, then a normal byte load
    if_req = 1'b1; if_addr = 32'h400;
    tick(2);
    check("rmid_ram_a", ram_a, 32'h401);
    rst = 1'b1; if_req = 1'b0;
    tick();
    check("rmid_ram_a_clr", ram_a, 32'h0);
    check("rmid_ram_wr", {31'h0, ram_wr}, 32'h0);
    check("rmid_if_done", {31'h0, if_done}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rmid_no_done", {31'h0, if_done}, 32'h0);
    end
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h403;
    tick();
    check("post_rst_ram_a", ram_a, 32'h403);
    tick(2);
    check("post_rst_done", {31'h0, mem_done}, 32'h1);
    check("post_rst_rdata", mem_rdata, 32'h0000_003B);
    mem_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter/sequencer for the shared byte-wide RAM bus between instruction fetch (IF/icache refill) and the MEM stage.
- Accepts one word-level request at a time, serialises it into byte cycles on the 8-bit RAM port (little-endian), assembles read data and returns it with a one-cycle done pulse.
- Sits between if_/mem and the top-level RAM pins in cpu.

Parameters:
- ADDR_W, 32, address width of requester and RAM address buses.
- IO_HI, 2'b11, value of addr[17:16] marking the I/O region; used to block IF access there.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  pause when low
- if_req  in  1  IF read request; held until if_done
- if_addr  in  ADDR_W  IF word address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  assembled instruction word
- mem_req  in  1  MEM request; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- mem_addr  in  ADDR_W  MEM byte address
- mem_wdata  in  32  store data; low bytes used
- mem_done  out  1  one-cycle pulse on completion
- mem_rdata  out  32  zero-extended load data
- ram_din  in  8  RAM read data (valid one cycle after address)
- ram_dout  out  8  RAM write data
- ram_a  out  ADDR_W  RAM address
- ram_wr  out  1  1 = write

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; if_done = mem_done = 0; if_data = mem_rdata = 0; ram_a = 0; ram_dout = 0; ram_wr = 0.
- Reset mid-transaction: abort to IDLE with no done pulse. A partially written store stays partially written.
- States:
  - IDLE: samples requests. MEM has fixed priority when both requests are high. Grants go to RD (load or IF) or WR (store). Byte count N = 1, 2 or 4; IF is always 4.
  - RD: in cycle k (k = 0..N-1) of the state, drive ram_a = addr + k and ram_wr = 0. Capture ram_din into byte k-1 at the end of cycle k. Cycle N captures byte N-1 with no new address, then goes to DONE.
  - WR: in cycle k, drive ram_a = addr + k, ram_dout = wdata[8k+7:8k] and ram_wr = 1. After cycle N-1, go to DONE.
  - DONE: pulse the granted done for exactly one cycle with data registered, then return to IDLE.
- Latency, counted from the IDLE sampling edge to the done cycle:
  - word read: 6 cycles
  - byte read: 3 cycles
  - word write: 5 cycles
  - byte write: 2 cycles
- Turnaround: IDLE always follows DONE, giving one bubble. Requesters must drop req in the cycle after observing done.
- Request rules:
  - Deasserting req mid-transaction is ignored; the transaction completes.
  - Address and wdata are latched at grant.
  - Address increment wraps modulo 2^ADDR_W. No alignment is required.
- IF request with if_addr[17:16] == IO_HI: complete with if_data = 0 and no RAM cycles, taking IDLE to DONE directly.
- Outside RD/WR: ram_wr = 0 and ram_a = 0.
- rdy low:
  - Freeze state, counters, capture registers, ram_a and ram_dout.
  - Force ram_wr = 0 and suppress done pulses.
  - When rdy returns, the held address is re-driven, so a read capture resumes one cycle later and a write byte is re-issued once.
- Loads: mem_rdata upper bytes are zero; sign extension belongs to the requester.

Optional Feature:
- MEM_ARBITER_FAIR_EN defined: round-robin priority. A last-granted flag toggles the winner when both requests are pending in IDLE.
- Undefined: fixed MEM-over-IF priority. IF may starve while MEM keeps its request asserted.

Decomposition:
- Shared package mem_arbiter_pkg holds:
  - state enum (IDLE, RD, WR, DONE)
  - size codes (SZ_B = 0, SZ_H = 1, SZ_W = 2)
  - IO_HI constant
  - byte-count function size_to_n
- Sub-module mem_arbiter_grant is natural: combinational pick plus the round-robin flag register under the macro.

Test Plan:
- IF word read at 0x00000100 with RAM bytes 13, 05, 00, 00 -> ram_a 0x100..0x103 on consecutive cycles; if_done 6 cycles after grant; if_data = 0x00000513.
- MEM byte store 0xAB to 0x00030000 -> exactly one cycle with ram_wr = 1, ram_a = 0x30000, ram_dout = 0xAB; mem_done the next cycle.
- Both requests asserted in IDLE (default build) -> MEM is granted first and IF is granted in the IDLE after mem_done. With MEM_ARBITER_FAIR_EN and repeated contention, grants alternate MEM, IF, MEM.
- Half load at 0xFFFFFFFF -> ram_a 0xFFFFFFFF then 0x00000000; mem_rdata = {16'h0, b1, b0}.
- rdy low for 3 cycles during byte 2 of a word write -> ram_wr = 0 while low; byte 2 written exactly once after resume; mem_done delayed by 3 cycles.
- rst asserted mid word read -> next cycle IDLE, no done pulse, ram_wr = 0; a subsequent request completes normally.
